// File: rtl/fft_twiddle_gen.sv
// fft_twiddle_gen: 3-stage pipelined twiddle factor generator for one FFT stage.
// Each factor comes from a quarter-wave cosine table plus quadrant symmetry.
// Unity magnitude is 2^(TWIDDLE_WIDTH-2), which matches the multiplier's truncation.
module fft_twiddle_gen #(
  parameter int    TWIDDLE_WIDTH = 10,
  parameter int    FFT_N         = 1024,
  parameter int    NLOG2         = 10,
  parameter int    STAGE_SHIFT   = 0,
  parameter string ROM_FILE      = "twiddle_cos.hex"
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic                            en_i,
  input  logic                            inv_i,
  input  logic        [NLOG2-1:0]         ctr_i,
  output logic                            valid_o,
  output logic        [NLOG2-1:0]         ctr_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);

  localparam int QTR = FFT_N / 4;
  localparam int AW  = NLOG2 - 1;

  // The table contents are computed at elaboration, so ROM_FILE is only a label for
  // the same values exported to a hex file.
  // cos(2*pi*m/N) evaluated with a 2^30 fixed-point Taylor series, then rounded to
  // the twiddle scale.
  function automatic logic signed [TWIDDLE_WIDTH-1:0] cos_entry(input int m);
    longint x;
    longint x2;
    longint term;
    longint acc;
    int     sh;
    x    = (longint'(m) * 64'sd6746518852) / longint'(FFT_N);
    x2   = (x * x) >>> 30;
    term = longint'(1) <<< 30;
    acc  = term;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      acc  = acc + term;
    end
    sh  = 30 - (TWIDDLE_WIDTH - 2);
    acc = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    return acc[TWIDDLE_WIDTH-1:0];
  endfunction

  logic signed [TWIDDLE_WIDTH-1:0] w_rom [0:QTR];

  for (genvar g = 0; g <= QTR; g++) begin : g_rom
    localparam logic signed [TWIDDLE_WIDTH-1:0] LP_C = cos_entry(g);
    assign w_rom[g] = LP_C;
  end

  // Stage 1 signals
  logic [NLOG2-1:0] w_k;
  logic [1:0]       r_s1_q;
  logic [NLOG2-3:0] r_s1_m;
  logic             r_s1_inv;
  logic [NLOG2-1:0] r_s1_ctr;
  logic             r_s1_vld;

  // Stage 2 signals
  logic [AW-1:0]                   w_addr_a;
  logic [AW-1:0]                   w_addr_b;
  logic signed [TWIDDLE_WIDTH-1:0] r_s2_a;
  logic signed [TWIDDLE_WIDTH-1:0] r_s2_b;
  logic [1:0]                      r_s2_q;
  logic                            r_s2_inv;
  logic [NLOG2-1:0]                r_s2_ctr;
  logic                            r_s2_vld;

  // Stage 3 signals
  logic signed [TWIDDLE_WIDTH-1:0] w_re;
  logic signed [TWIDDLE_WIDTH-1:0] w_im;
  logic                            r_valid;
  logic [NLOG2-1:0]                r_ctr;
  logic signed [TWIDDLE_WIDTH-1:0] r_re;
  logic signed [TWIDDLE_WIDTH-1:0] r_im;

  // The shift simply drops the bits above NLOG2, which gives k modulo N.
  assign w_k = NLOG2'(ctr_i << STAGE_SHIFT);

  // Stage 1: split the index into quadrant and in-quadrant offset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_s1_q   <= '0;
      r_s1_m   <= '0;
      r_s1_inv <= 1'b0;
      r_s1_ctr <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= en_i;
      if (en_i) begin
        r_s1_q   <= w_k[NLOG2-1:NLOG2-2];
        r_s1_m   <= w_k[NLOG2-3:0];
        r_s1_inv <= inv_i;
        r_s1_ctr <= ctr_i;
      end
    end
  end

  // The complementary address N/4-m stays in 1..N/4 for m != 0 and equals N/4 for
  // m = 0, so it never wraps.
  assign w_addr_a = AW'(r_s1_m);
  assign w_addr_b = AW'(QTR) - AW'(r_s1_m);

  // Stage 2: dual registered table read of cos(m) and cos(N/4-m) = sin(m).
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_s2_a   <= '0;
      r_s2_b   <= '0;
      r_s2_q   <= '0;
      r_s2_inv <= 1'b0;
      r_s2_ctr <= '0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_a   <= w_rom[w_addr_a];
        r_s2_b   <= w_rom[w_addr_b];
        r_s2_q   <= r_s1_q;
        r_s2_inv <= r_s1_inv;
        r_s2_ctr <= r_s1_ctr;
      end
    end
  end

  // Quadrant symmetry followed by the optional conjugate. Table magnitudes never
  // exceed unity, so negation cannot overflow.
  always_comb begin
    w_re = r_s2_a;
    w_im = -r_s2_b;
    case (r_s2_q)
      2'd0: begin w_re = r_s2_a;  w_im = -r_s2_b; end
      2'd1: begin w_re = -r_s2_b; w_im = -r_s2_a; end
      2'd2: begin w_re = -r_s2_a; w_im = r_s2_b;  end
      default: begin w_re = r_s2_b; w_im = r_s2_a; end
    endcase
    if (r_s2_inv) begin
      w_im = -w_im;
    end
  end

  // Stage 3: output registers keep their last values across bubbles.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctr   <= '0;
      r_re    <= '0;
      r_im    <= '0;
    end else begin
      r_valid <= r_s2_vld;
      if (r_s2_vld) begin
        r_ctr <= r_s2_ctr;
        r_re  <= w_re;
        r_im  <= w_im;
      end
    end
  end

  assign valid_o = r_valid;
  assign ctr_o   = r_ctr;
  assign w_re_o  = r_re;
  assign w_im_o  = r_im;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// tb_fft_twiddle_gen: directed tests of the twiddle generator, N=1024, TW=10.
// A second instance with STAGE_SHIFT=2 shares the inputs for the decimation test.
module tb_fft_twiddle_gen;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic              en_i  = 1'b0;
  logic              inv_i = 1'b0;
  logic        [9:0] ctr_i = '0;

  logic              valid_a;
  logic        [9:0] ctr_a;
  logic signed [9:0] re_a;
  logic signed [9:0] im_a;

  logic              valid_b;
  logic        [9:0] ctr_b;
  logic signed [9:0] re_b;
  logic signed [9:0] im_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fft_twiddle_gen #(
    .TWIDDLE_WIDTH(10), .FFT_N(1024), .NLOG2(10), .STAGE_SHIFT(0), .ROM_FILE("twiddle_cos.hex")
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .inv_i(inv_i), .ctr_i(ctr_i),
    .valid_o(valid_a), .ctr_o(ctr_a), .w_re_o(re_a), .w_im_o(im_a)
  );

  fft_twiddle_gen #(
    .TWIDDLE_WIDTH(10), .FFT_N(1024), .NLOG2(10), .STAGE_SHIFT(2), .ROM_FILE("twiddle_cos.hex")
  ) dut_s2 (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .inv_i(inv_i), .ctr_i(ctr_i),
    .valid_o(valid_b), .ctr_o(ctr_b), .w_re_o(re_b), .w_im_o(im_b)
  );

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (valid_a !== 1'b0 || ctr_a !== 10'd0 || re_a !== 10'sd0 || im_a !== 10'sd0) begin
      errors++;
      $display("[TB] FAIL reset_main: got v=%b ctr=%0d re=%0d im=%0d, want all 0", valid_a, ctr_a, re_a, im_a);
    end
    checks++;
    if (valid_b !== 1'b0 || ctr_b !== 10'd0 || re_b !== 10'sd0 || im_b !== 10'sd0) begin
      errors++;
      $display("[TB] FAIL reset_shift: got v=%b ctr=%0d re=%0d im=%0d, want all 0", valid_b, ctr_b, re_b, im_b);
    end
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_axes(input logic inv);
    int ctrs[5] = '{0, 128, 256, 512, 768};
    int er[5]   = '{256, 181, 0, -256, 0};
    int ei[5]   = '{0, -181, -256, 0, 256};
    for (int t = 0; t < 8; t++) begin
      @(negedge clk_i);
      if (t >= 3) begin
        int i = t - 3;
        int want_im = inv ? -ei[i] : ei[i];
        checks++;
        if (valid_a !== 1'b1 || ctr_a !== 10'(ctrs[i])) begin
          errors++;
          $display("[TB] FAIL axes_ctl inv=%0d i=%0d: got v=%b ctr=%0d, want v=1 ctr=%0d", inv, i, valid_a, ctr_a, ctrs[i]);
        end
        checks++;
        if (re_a !== 10'(er[i]) || im_a !== 10'(want_im)) begin
          errors++;
          $display("[TB] FAIL axes_w inv=%0d i=%0d: got (%0d,%0d), want (%0d,%0d)", inv, i, re_a, im_a, er[i], want_im);
        end
      end
      if (t < 5) begin
        en_i  = 1'b1;
        inv_i = inv;
        ctr_i = 10'(ctrs[t]);
      end else begin
        en_i = 1'b0;
      end
    end
  endtask

  task automatic test_sweep();
    for (int t = 0; t < 1027; t++) begin
      @(negedge clk_i);
      if (t >= 3) begin
        int  k   = t - 3;
        real th  = 2.0 * 3.14159265358979323846 * real'(k) / 1024.0;
        int  mr  = rnd(256.0 * $cos(th));
        int  mi  = (k % 2 == 1) ? rnd(256.0 * $sin(th)) : rnd(-256.0 * $sin(th));
        int  dr  = int'(re_a) - mr;
        int  di  = int'(im_a) - mi;
        int  mag = int'(re_a) * int'(re_a) + int'(im_a) * int'(im_a);
        checks++;
        if (valid_a !== 1'b1 || ctr_a !== 10'(k)) begin
          errors++;
          $display("[TB] FAIL sweep_ctl k=%0d: got v=%b ctr=%0d, want v=1 ctr=%0d", k, valid_a, ctr_a, k);
        end
        checks++;
        if (dr > 1 || dr < -1 || di > 1 || di < -1) begin
          errors++;
          $display("[TB] FAIL sweep_w k=%0d: got (%0d,%0d), want (%0d,%0d) +-1", k, re_a, im_a, mr, mi);
        end
        checks++;
        if (mag < 64226 || mag > 66846) begin
          errors++;
          $display("[TB] FAIL sweep_mag k=%0d: got %0d, want 64226..66846", k, mag);
        end
      end
      if (t < 1024) begin
        en_i  = 1'b1;
        inv_i = t[0];
        ctr_i = 10'(t);
      end else begin
        en_i = 1'b0;
      end
    end
  endtask

  task automatic test_stage_shift();
    int ctrs[2] = '{256, 32};
    int er[2]   = '{256, 181};
    int ei[2]   = '{0, -181};
    for (int t = 0; t < 5; t++) begin
      @(negedge clk_i);
      if (t >= 3) begin
        int i = t - 3;
        checks++;
        if (valid_b !== 1'b1 || ctr_b !== 10'(ctrs[i]) || re_b !== 10'(er[i]) || im_b !== 10'(ei[i])) begin
          errors++;
          $display("[TB] FAIL shift i=%0d: got v=%b ctr=%0d (%0d,%0d), want v=1 ctr=%0d (%0d,%0d)",
                   i, valid_b, ctr_b, re_b, im_b, ctrs[i], er[i], ei[i]);
        end
      end
      if (t < 2) begin
        en_i  = 1'b1;
        inv_i = 1'b0;
        ctr_i = 10'(ctrs[t]);
      end else begin
        en_i = 1'b0;
      end
    end
  endtask

  task automatic test_bubbles();
    logic en_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int   ev[5]     = '{1, 0, 1, 1, 0};
    int   ec[5]     = '{10, 10, 12, 13, 13};
    int   er[5]     = '{256, 256, 255, 255, 255};
    int   ei[5]     = '{-16, -16, -19, -20, -20};
    for (int t = 0; t < 8; t++) begin
      @(negedge clk_i);
      if (t >= 3) begin
        int i = t - 3;
        checks++;
        if (valid_a !== 1'(ev[i]) || ctr_a !== 10'(ec[i]) || re_a !== 10'(er[i]) || im_a !== 10'(ei[i])) begin
          errors++;
          $display("[TB] FAIL bubble i=%0d: got v=%b ctr=%0d (%0d,%0d), want v=%0d ctr=%0d (%0d,%0d)",
                   i, valid_a, ctr_a, re_a, im_a, ev[i], ec[i], er[i], ei[i]);
        end
      end
      if (t < 5) begin
        en_i  = en_pat[t];
        inv_i = 1'b0;
        ctr_i = 10'(10 + t);
      end else begin
        en_i = 1'b0;
      end
    end
  endtask

  task automatic test_midstream_reset();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk_i);
      en_i  = 1'b1;
      inv_i = 1'b0;
      ctr_i = 10'(100 + t);
    end
    @(negedge clk_i);
    checks++;
    if (valid_a !== 1'b1 || ctr_a !== 10'd100) begin
      errors++;
      $display("[TB] FAIL pre_reset: got v=%b ctr=%0d, want v=1 ctr=100", valid_a, ctr_a);
    end
    rst_n = 1'b0;
    en_i  = 1'b0;
    @(negedge clk_i);
    checks++;
    if (valid_a !== 1'b0 || ctr_a !== 10'd0 || re_a !== 10'sd0 || im_a !== 10'sd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got v=%b ctr=%0d re=%0d im=%0d, want all 0", valid_a, ctr_a, re_a, im_a);
    end
    rst_n = 1'b1;
    en_i  = 1'b1;
    ctr_i = 10'd200;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk_i);
      en_i = 1'b0;
      if (t < 3) begin
        checks++;
        if (valid_a !== 1'b0) begin
          errors++;
          $display("[TB] FAIL post_reset_stale t=%0d: got v=%b, want 0", t, valid_a);
        end
      end else begin
        checks++;
        if (valid_a !== 1'b1 || ctr_a !== 10'd200 || re_a !== 10'sd86 || im_a !== -10'sd241) begin
          errors++;
          $display("[TB] FAIL post_reset_first: got v=%b ctr=%0d (%0d,%0d), want v=1 ctr=200 (86,-241)",
                   valid_a, ctr_a, re_a, im_a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_axes(1'b0);
    test_axes(1'b1);
    test_sweep();
    test_stage_shift();
    test_bubbles();
    test_midstream_reset();
    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_gen.md
Name: fft_twiddle_gen

Overview:
Supplies twiddle factors W = exp(∓j2πk/N) to the FFT twiddle-multiply stage (w_re/w_im inputs), with the sample counter delayed to stay aligned with the factor. A quarter-wave cosine ROM plus quadrant symmetry produces each factor in fixed-point. The factor scaling matches the multiplier's output truncation: unity = 2^(TWIDDLE_WIDTH-2). The block is a fixed-latency, 3-stage pipeline with a valid bit, instantiated once per FFT stage.

Parameters:
TWIDDLE_WIDTH, 10, signed width of w_re_o/w_im_o; unity magnitude = 2^(TWIDDLE_WIDTH-2).
FFT_N, 1024, transform length; power of two, minimum 8.
NLOG2, 10, log2(FFT_N).
STAGE_SHIFT, 0, twiddle index k = (ctr_i << STAGE_SHIFT) mod FFT_N (stage decimation).
ROM_FILE, "twiddle_cos.hex", hex init file for C[m], m = 0..FFT_N/4.

Ports:
clk_i  in  1  single clock; all state is updated on the rising edge.
rst_n  in  1  synchronous reset, active-low.
en_i  in  1  input sample valid; ctr_i and inv_i are sampled only when en_i = 1.
inv_i  in  1  0: forward, W = cos θ − j sin θ; 1: inverse, conjugate, W = cos θ + j sin θ.
ctr_i  in  NLOG2  sample index within the frame.
valid_o  out  1  w_*_o and ctr_o are valid.
ctr_o  out  NLOG2  ctr_i delayed to align with w_*_o.
w_re_o  out  TWIDDLE_WIDTH  signed real part of the twiddle.
w_im_o  out  TWIDDLE_WIDTH  signed imaginary part of the twiddle.

Behaviour:
- Reset: while rst_n = 0 at a clock edge, valid_o, ctr_o, w_re_o, w_im_o and all pipeline valid/data registers go to 0. A reset mid-stream flushes the pipeline; no stale output appears after reset releases.
- Latency: exactly 3 clk_i cycles from an en_i = 1 sample to valid_o = 1 with the matching data. The pipeline runs continuously with no stall input. Throughput is one factor per cycle.
- Holding outputs: when a bubble (en_i = 0) reaches the output, valid_o = 0 and w_*_o/ctr_o keep their last values.
- ROM: C[m] = round(2^(TWIDDLE_WIDTH-2) · cos(2πm/N)), m = 0..N/4 (N/4+1 entries), registered read. Two reads are performed per cycle, at addresses m and N/4−m (dual-port or duplicated ROM).
- Stage 1: compute k = (ctr_i << STAGE_SHIFT) mod N; truncate, no overflow flag. Register the quadrant q = k[NLOG2-1:NLOG2-2], m = k[NLOG2-3:0], inv_i, ctr_i and valid.
- Stage 2: register the ROM outputs A = C[m] and B = C[N/4−m]. When m = 0, B = C[N/4] = 0. The address N/4−m lies in 1..N/4 for m ≠ 0 and must not wrap.
- Stage 3: apply quadrant symmetry, then the conjugate.
  - q=0: re = A, im = −B
  - q=1: re = −B, im = −A
  - q=2: re = −A, im = B
  - q=3: re = B, im = A
  - If inv = 1, im is negated.
  - Negation is exact because |C| ≤ 2^(TWIDDLE_WIDTH-2), so the result always fits and never saturates.
- Wrap-around: ctr_i passing from N−1 to 0 needs no special handling. k wraps modulo N naturally.
- inv_i may change every cycle; it travels with its own sample.
- Combined with the multiplier's truncation of bits [DATA+TW-3:TW-2], |W| = 1 gives unity gain.

Test Plan:
1. N=1024, TW=10, inv=0, ctr_i = 0, 128, 256, 512, 768 on consecutive cycles -> 3 cycles later, one per cycle: (256, 0), (181, −181), (0, −256), (−256, 0), (0, 256); ctr_o matches the inputs and valid_o = 1.
2. Same as 1 with inv=1 -> imaginary parts negated: 0, 181, 256, 0, −256; real parts unchanged.
3. Full sweep ctr_i = 0..1023 with en_i = 1 every cycle, compared against a double-precision model rounded ×256 -> |error| ≤ 1 LSB and re²+im² within ±2% of 65536 for every k; ctr_o = ctr_i delayed 3 cycles.
4. STAGE_SHIFT=2, ctr_i = 256 -> k = 0 -> (256, 0); ctr_i = 32 -> k = 128 -> (181, −181); ctr_o = 256 and 32 respectively.
5. en_i pattern 1,0,1,1,0 with ctr_i = 10..14 -> valid_o = 1,0,1,1,0 starting at cycle 3; outputs hold their values during bubbles.
6. Assert rst_n = 0 for one cycle while 3 samples are in flight -> valid_o = 0 and all outputs 0 the next cycle; the first sample after release appears exactly 3 cycles after its en_i.
